seq_load_packer: RTL and testbench
==================================

# seq_load_packer

Sequential load data packer for the VLSU read path; the counterpart of the sequential store controller. It accepts AXI R beats, uses the per-beat transaction control to strip the head and tail nibbles, and packs the valid nibbles contiguously into lane-wide sequential-buffer entries. It forwards those entries through a 2-entry ping-pong buffer to the ShuffleUnit. Data is handled at nibble granularity, so every supported SEW and address alignment is covered.

## Interface
- NrLanes, default 4: number of vector lanes.
- AxiDataWidth, default 128: AXI R data width in bits. busNibbles = AxiDataWidth/4 and busNSize = log2(busNibbles).
- Dlen, default 64: per-lane datapath width in bits. EntryNbs = Dlen/4*NrLanes, which is 64 nibbles at the defaults.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- axi_r_valid_i / axi_r_ready_o  in/out  1  R channel handshake.
- axi_r_data_i  in  AxiDataWidth  R data.
- axi_r_resp_i  in  2  R response.
- axi_r_last_i  in  1  R last.
- txn_ctrl_valid_i / txn_ctrl_ready_o  in/out  1  per-beat control handshake.
- txn_ctrl_i  in  struct  per-beat control, fields:
  - addr: beat address.
  - isHead: first beat of the transaction.
  - rmnBeat: remaining beats; 0 on the last beat.
  - lbN: valid nibbles in the last beat, range 1..busNibbles, width busNSize+1.
  - isFinalTxn: final transaction of the request.
- meta_glb_valid_i / meta_glb_ready_o  in/out  1  per-request metadata handshake.
- meta_glb_i  in  struct  request metadata: vstart and sew (0..3 encodes 8..64 bit elements).
- tx_shfu_valid_o / tx_shfu_ready_i  out/in  1  entry handshake to the ShuffleUnit.
- tx_shfu_o  out  EntryNbs*5  output entry: nb[4*EntryNbs-1:0] data and en[EntryNbs-1:0] nibble enables.
- err_o  out  1  sticky error flag (see Configuration).

## Operation
- **States:** S_IDLE and S_SERIAL.
- **Request start:** meta_glb_ready_o = (state == S_IDLE). On the meta handshake:
  - seq_nb_ptr = (vstart << (sew+1)) mod EntryNbs.
  - bus_nb_cnt = 0.
  - State moves to S_SERIAL.
- **Per-cycle bounds in S_SERIAL:**
  - lower = isHead ? addr[busNSize-1:0] : 0.
  - upper = (rmnBeat == 0) ? lbN : busNibbles.
  - bus_valid = upper - lower - bus_nb_cnt, width busNSize+1.
  - ent_valid = EntryNbs - seq_nb_ptr.
- **Step condition:** axi_r_valid_i && txn_ctrl_valid_i && !buf_full.
- **Step when bus_valid > ent_valid (partial beat):**
  - Copy ent_valid nibbles and commit the entry.
  - bus_nb_cnt += ent_valid; seq_nb_ptr = 0.
  - Do not pop the R beat or the control word.
- **Step when bus_valid <= ent_valid (full beat):**
  - Copy bus_valid nibbles and pop both: axi_r_ready_o = txn_ctrl_ready_o = 1.
  - bus_nb_cnt = 0; seq_nb_ptr += bus_valid.
  - If bus_valid == ent_valid, or the beat is final (isFinalTxn && rmnBeat == 0): commit the entry and set seq_nb_ptr = 0.
- **Copy mapping:** bus nibble i, for start <= i < upper with start = lower + bus_nb_cnt, goes to entry nibble i - start + seq_nb_ptr and sets en = 1 there.
- **Entry enables:** a newly allocated entry starts with en all 0. Nibbles below the vstart offset and past the final nibble therefore stay disabled.
- **Request end:** after the final beat pops, state returns to S_IDLE.
- **Buffer:** 2-entry circular buffer with flag/value pointers.
  - tx_shfu_valid_o = !empty.
  - An entry is dequeued on the tx handshake.
  - full and empty are computed from registered pointers only; a dequeue does not free space in the same cycle.

## Timing
- **Reset values:**
  - axi_r_ready_o = 0, txn_ctrl_ready_o = 0, tx_shfu_valid_o = 0, err_o = 0.
  - meta_glb_ready_o = 1.
  - State S_IDLE; pointers and counters 0.
- **Ready paths:** axi_r_ready_o and txn_ctrl_ready_o are combinational from state, txn_ctrl_i, the counters, full, and the valids. They are asserted only when both valids are high; there is no dependence on tx_shfu_ready_i.
- **Commit latency:** a committed entry is visible on tx_shfu_o the cycle after the commit.
- **Throughput:** at most one R beat accepted per cycle. A beat that straddles two entries takes 2 cycles.
- **Simultaneous commit and dequeue when not full:** both take effect.
- **Wrap-around:** pointer flag toggles on value wrap.
- **Reset mid-request:** everything clears asynchronously, partial entries are discarded, and no output is produced until a new meta handshake.
- **Assertions:**
  - upper <= busNibbles.
  - bus_valid <= busNibbles.
  - No control-word handshake while in S_IDLE.

## Configuration
- **SEQ_LOAD_RESP_CHECK_EN defined:**
  - err_o sets on any accepted beat with axi_r_resp_i != OKAY.
  - err_o also sets when axi_r_last_i != (rmnBeat == 0).
  - err_o stays set until reset.
  - Data flow is unaffected.
- **Macro undefined:** err_o is tied to 0 and no check logic is built.

## Test plan
- **Aligned request:** vstart=0, addr=0, two beats with rmnBeat 1,0, lbN=32, isFinalTxn=1. Expect one entry with en all 1; nb[0..31] = beat0 and nb[32..63] = beat1; ready high on both beats.
- **Head misalignment:** addr[4:0]=8, three beats, lbN=8. Expect 24+32+8 = 64 nibbles in one entry; entry nibble 0 = beat0 bus nibble 8; commit on the final beat.
- **Beat straddling entries:** vstart=10, sew=1 gives seq_nb_ptr=40. First beat:
  - Cycle 1: entry0 commits with en[0..39]=0 and en[40..63]=1; axi_r_ready_o=0.
  - Cycle 2: bus nibbles 24..31 go to entry1 nibbles 0..7 and the beat pops.
- **Backpressure:** hold tx_shfu_ready_i=0 until two entries are committed. Expect axi_r_ready_o=0 while full; after one tx handshake, acceptance resumes on the next cycle.
- **Reset mid-request:** assert rst_ni low after one beat. Expect all outputs at reset values immediately; a following aligned request produces correct data.
- **Error check:** with SEQ_LOAD_RESP_CHECK_EN, send axi_r_resp_i=2'b10 on beat 1. Expect err_o=1 from the next cycle and staying set; without the macro, err_o stays 0.

Source files
------------

// File: rtl/seq_load_packer.sv
// Sequential load packer: strips head/tail nibbles of AXI R beats and packs the rest into
// lane-wide entries behind a 2-entry buffer. Define SEQ_LOAD_RESP_CHECK_EN to build the err_o check.
module seq_load_packer #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned Dlen         = 64,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned RmnBeatWidth = 8,
  parameter int unsigned VstartWidth  = 16,
  localparam int unsigned BusNibbles   = AxiDataWidth / 4,
  localparam int unsigned BusNSize     = $clog2(BusNibbles),
  localparam int unsigned EntryNbs     = Dlen / 4 * NrLanes,
  localparam int unsigned EntryNSize   = $clog2(EntryNbs),
  localparam int unsigned TxnCtrlWidth = AddrWidth + 1 + RmnBeatWidth + BusNSize + 1 + 1,
  localparam int unsigned MetaGlbWidth = VstartWidth + 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    axi_r_valid_i,
  output logic                    axi_r_ready_o,
  input  logic [AxiDataWidth-1:0] axi_r_data_i,
  input  logic [1:0]              axi_r_resp_i,
  input  logic                    axi_r_last_i,
  input  logic                    txn_ctrl_valid_i,
  output logic                    txn_ctrl_ready_o,
  input  logic [TxnCtrlWidth-1:0] txn_ctrl_i,
  input  logic                    meta_glb_valid_i,
  output logic                    meta_glb_ready_o,
  input  logic [MetaGlbWidth-1:0] meta_glb_i,
  output logic                    tx_shfu_valid_o,
  input  logic                    tx_shfu_ready_i,
  output logic [EntryNbs*5-1:0]   tx_shfu_o,
  output logic                    err_o
);

  localparam int unsigned EntryBits = 4 * EntryNbs;
  localparam logic [BusNSize:0]   BusNbsL   = (BusNSize + 1)'(BusNibbles);
  localparam logic [EntryNSize:0] EntryNbsL = (EntryNSize + 1)'(EntryNbs);

  typedef struct packed {
    logic [AddrWidth-1:0]    addr;
    logic                    is_head;
    logic [RmnBeatWidth-1:0] rmn_beat;
    logic [BusNSize:0]       lb_n;
    logic                    is_final_txn;
  } txn_ctrl_t;

  typedef struct packed {
    logic [VstartWidth-1:0] vstart;
    logic [1:0]             sew;
  } meta_glb_t;

  typedef enum logic [0:0] {StIdle, StSerial} state_e;

  txn_ctrl_t ctrl;
  meta_glb_t meta;
  assign ctrl = txn_ctrl_t'(txn_ctrl_i);
  assign meta = meta_glb_t'(meta_glb_i);

  state_e                state_q;
  logic [EntryNSize-1:0] seq_nb_ptr_q;
  logic [BusNSize:0]     bus_nb_cnt_q;
  logic [EntryBits-1:0]  stg_nb_q;
  logic [EntryNbs-1:0]   stg_en_q;
  logic [EntryBits-1:0]  buf_nb_q [2];
  logic [EntryNbs-1:0]   buf_en_q [2];
  logic [1:0]            wr_ptr_q, rd_ptr_q;

  logic                    full, empty, step, partial, is_final, pop, commit, deq;
  logic [BusNSize:0]       lower, upper, start, bus_valid;
  logic [EntryNSize:0]     ent_valid, n_copy;
  logic [BusNibbles-1:0]   nib_mask;
  logic [AxiDataWidth-1:0] bus_shift, bus_sel;
  logic [EntryBits-1:0]    mrg_nb;
  logic [EntryNbs-1:0]     mrg_en;
  logic [EntryNSize-1:0]   vstart_off;

  // Flag bit in [1], slot index in [0]; full/empty use registered pointers only.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[1] != rd_ptr_q[1]) && (wr_ptr_q[0] == rd_ptr_q[0]);
  assign deq   = !empty && tx_shfu_ready_i;

  assign vstart_off = EntryNSize'(meta.vstart << ({1'b0, meta.sew} + 3'd1));

  always_comb begin
    lower     = ctrl.is_head ? {1'b0, ctrl.addr[BusNSize-1:0]} : '0;
    upper     = (ctrl.rmn_beat == '0) ? ctrl.lb_n : BusNbsL;
    start     = lower + bus_nb_cnt_q;
    bus_valid = upper - start;
    ent_valid = EntryNbsL - {1'b0, seq_nb_ptr_q};
    partial   = (EntryNSize + 1)'(bus_valid) > ent_valid;
    n_copy    = partial ? ent_valid : (EntryNSize + 1)'(bus_valid);
    bus_shift = axi_r_data_i >> {start, 2'b00};
    nib_mask  = '0;
    bus_sel   = '0;
    for (int unsigned i = 0; i < BusNibbles; i++) begin
      nib_mask[i]      = (EntryNSize + 1)'(i) < n_copy;
      bus_sel[4*i +: 4] = nib_mask[i] ? bus_shift[4*i +: 4] : 4'h0;
    end
    mrg_nb = stg_nb_q | (EntryBits'(bus_sel) << {seq_nb_ptr_q, 2'b00});
    mrg_en = stg_en_q | (EntryNbs'(nib_mask) << seq_nb_ptr_q);
  end

  assign step     = (state_q == StSerial) && axi_r_valid_i && txn_ctrl_valid_i && !full;
  assign is_final = ctrl.is_final_txn && (ctrl.rmn_beat == '0);
  assign pop      = step && !partial;
  assign commit   = step && (partial || ((EntryNSize + 1)'(bus_valid) == ent_valid) || is_final);

  assign axi_r_ready_o    = pop;
  assign txn_ctrl_ready_o = pop;
  assign meta_glb_ready_o = (state_q == StIdle);
  assign tx_shfu_valid_o  = !empty;
  assign tx_shfu_o        = {buf_nb_q[rd_ptr_q[0]], buf_en_q[rd_ptr_q[0]]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      seq_nb_ptr_q <= '0;
      bus_nb_cnt_q <= '0;
      stg_nb_q     <= '0;
      stg_en_q     <= '0;
      buf_nb_q     <= '{default: '0};
      buf_en_q     <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      if (deq) rd_ptr_q <= rd_ptr_q + 2'd1;
      case (state_q)
        StIdle: begin
          if (meta_glb_valid_i) begin
            state_q      <= StSerial;
            seq_nb_ptr_q <= vstart_off;
            bus_nb_cnt_q <= '0;
            stg_nb_q     <= '0;
            stg_en_q     <= '0;
          end
        end
        StSerial: begin
          if (step) begin
            if (commit) begin
              buf_nb_q[wr_ptr_q[0]] <= mrg_nb;
              buf_en_q[wr_ptr_q[0]] <= mrg_en;
              wr_ptr_q              <= wr_ptr_q + 2'd1;
              stg_nb_q              <= '0;
              stg_en_q              <= '0;
            end else begin
              stg_nb_q <= mrg_nb;
              stg_en_q <= mrg_en;
            end
            if (partial) begin
              // Beat straddles two entries: keep it on the bus, resume after the copied part.
              bus_nb_cnt_q <= bus_nb_cnt_q + (BusNSize + 1)'(ent_valid);
              seq_nb_ptr_q <= '0;
            end else begin
              bus_nb_cnt_q <= '0;
              seq_nb_ptr_q <= commit ? '0 : seq_nb_ptr_q + EntryNSize'(bus_valid);
              if (is_final) state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SEQ_LOAD_RESP_CHECK_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (pop && ((axi_r_resp_i != 2'b00) || (axi_r_last_i != (ctrl.rmn_beat == '0)))) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{ctrl.addr[AddrWidth-1:BusNSize], axi_r_resp_i, axi_r_last_i};

  a_upper_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StSerial && axi_r_valid_i && txn_ctrl_valid_i) |-> (upper <= BusNbsL));
  a_bus_valid_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StSerial && axi_r_valid_i && txn_ctrl_valid_i) |-> (bus_valid <= BusNbsL));
  a_no_ctrl_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StIdle) |-> !(txn_ctrl_valid_i && txn_ctrl_ready_o));

endmodule

// File: tb/tb_seq_load_packer.sv
// Randomised scoreboard bench for seq_load_packer: a nibble-stream reference model predicts
// every entry, a monitor compares each tx handshake against the expected queue.
module tb_seq_load_packer;

  logic         clk, rst_n;
  logic         axi_r_valid, axi_r_ready, axi_r_last;
  logic [127:0] axi_r_data;
  logic [1:0]   axi_r_resp;
  logic         txn_ctrl_valid, txn_ctrl_ready;
  logic [47:0]  txn_ctrl;
  logic         meta_valid, meta_ready;
  logic [17:0]  meta;
  logic         tx_valid, tx_ready;
  logic [319:0] tx_shfu;
  logic         err;

`ifdef SEQ_LOAD_RESP_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  seq_load_packer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .axi_r_valid_i    (axi_r_valid),
    .axi_r_ready_o    (axi_r_ready),
    .axi_r_data_i     (axi_r_data),
    .axi_r_resp_i     (axi_r_resp),
    .axi_r_last_i     (axi_r_last),
    .txn_ctrl_valid_i (txn_ctrl_valid),
    .txn_ctrl_ready_o (txn_ctrl_ready),
    .txn_ctrl_i       (txn_ctrl),
    .meta_glb_valid_i (meta_valid),
    .meta_glb_ready_o (meta_ready),
    .meta_glb_i       (meta),
    .tx_shfu_valid_o  (tx_valid),
    .tx_shfu_ready_i  (tx_ready),
    .tx_shfu_o        (tx_shfu),
    .err_o            (err)
  );

  typedef struct {
    logic [127:0] data;
    logic [31:0]  addr;
    bit           head;
    int unsigned  rmn;
    int unsigned  lbn;
    bit           fin;
    logic [1:0]   resp;
  } beat_t;

  beat_t        req_q[$];
  logic [255:0] exp_nb_q[$];
  logic [63:0]  exp_en_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           tx_mode = 2;  // 0 random ready, 1 manual, 2 always ready

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic void add_beat(logic [31:0] addr, bit head, int unsigned rmn,
                                   int unsigned lbn, bit fin, logic [1:0] resp);
    beat_t b;
    b.data = {$urandom, $urandom, $urandom, $urandom};
    b.addr = addr;
    b.head = head;
    b.rmn  = rmn;
    b.lbn  = lbn;
    b.fin  = fin;
    b.resp = resp;
    req_q.push_back(b);
  endfunction

  // Reference: concatenate every valid nibble of the request, then lay the stream out
  // from the vstart offset into 64-nibble entries.
  function automatic void model_req(int unsigned sew, int unsigned vstart);
    logic [3:0]   stream[$];
    logic [255:0] nb;
    logic [63:0]  en;
    int unsigned  lo, up, pos;
    foreach (req_q[k]) begin
      lo = req_q[k].head ? (req_q[k].addr % 32) : 0;
      up = (req_q[k].rmn == 0) ? req_q[k].lbn : 32;
      for (int unsigned i = lo; i < up; i++) stream.push_back(req_q[k].data[4*i +: 4]);
    end
    pos = (vstart * (1 << (sew + 1))) % 64;
    nb  = '0;
    en  = '0;
    foreach (stream[j]) begin
      nb[4*pos +: 4] = stream[j];
      en[pos]        = 1'b1;
      pos++;
      if (pos == 64) begin
        exp_nb_q.push_back(nb);
        exp_en_q.push_back(en);
        nb  = '0;
        en  = '0;
        pos = 0;
      end
    end
    if (en != '0) begin
      exp_nb_q.push_back(nb);
      exp_en_q.push_back(en);
    end
  endfunction

  function automatic void gen_random_req();
    int unsigned ntxn, nbeat, lo, rmn, lbn;
    logic [31:0] addr;
    ntxn = $urandom_range(1, 3);
    for (int t = 0; t < int'(ntxn); t++) begin
      nbeat = $urandom_range(1, 3);
      lo    = $urandom_range(0, 31);
      addr  = ($urandom & 32'hffff_ffe0) | lo;
      for (int b = 0; b < int'(nbeat); b++) begin
        rmn = nbeat - 1 - b;
        lbn = (rmn == 0 && nbeat == 1) ? $urandom_range(lo + 1, 32) : $urandom_range(1, 32);
        add_beat(addr + 32'(16 * b), b == 0, rmn, lbn, t == int'(ntxn) - 1, 2'b00);
      end
    end
  endfunction

  task automatic set_beat(input beat_t b);
    axi_r_valid    = 1'b1;
    txn_ctrl_valid = 1'b1;
    axi_r_data     = b.data;
    axi_r_resp     = b.resp;
    axi_r_last     = (b.rmn == 0);
    txn_ctrl       = {b.addr, b.head, 8'(b.rmn), 6'(b.lbn), b.fin};
  endtask

  task automatic clear_beat();
    axi_r_valid    = 1'b0;
    txn_ctrl_valid = 1'b0;
    axi_r_data     = {$urandom, $urandom, $urandom, $urandom};
    axi_r_resp     = 2'b00;
    axi_r_last     = 1'b0;
  endtask

  task automatic drive_beat(input beat_t b, output int cyc);
    logic r, rc;
    set_beat(b);
    cyc = 0;
    r   = 1'b0;
    rc  = 1'b0;
    while (!r && cyc < 500) begin
      @(negedge clk);
      r  = axi_r_ready;
      rc = txn_ctrl_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("beat_accept", r, 1'b1);
    check("ctrl_ready", rc, 1'b1);
    clear_beat();
  endtask

  task automatic send_meta(input int unsigned sew, input int unsigned vstart);
    logic r;
    int   cyc;
    meta_valid = 1'b1;
    meta       = {16'(vstart), 2'(sew)};
    r          = 1'b0;
    cyc        = 0;
    while (!r && cyc < 500) begin
      @(negedge clk);
      r = meta_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("meta_accept", r, 1'b1);
    meta_valid = 1'b0;
  endtask

  task automatic send_req(input int unsigned sew, input int unsigned vstart, input bit gaps);
    int cyc;
    send_meta(sew, vstart);
    for (int k = 0; k < req_q.size(); k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      drive_beat(req_q[k], cyc);
    end
    req_q.delete();
  endtask

  task automatic wait_drain();
    int cyc;
    tx_mode = 2;
    cyc     = 0;
    while ((exp_nb_q.size() != 0 || tx_valid) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_left", 32'(exp_nb_q.size()), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_mode == 0) tx_ready = ($urandom_range(0, 3) != 0);
      else if (tx_mode == 2) tx_ready = 1'b1;
    end
  end

  initial begin
    logic [255:0] e_nb;
    logic [63:0]  e_en;
    forever begin
      @(negedge clk);
      if (rst_n && tx_valid && tx_ready) begin
        if (exp_en_q.size() == 0) begin
          check("unexpected_entry", tx_shfu[63:0], 64'h0);
        end else begin
          e_nb = exp_nb_q.pop_front();
          e_en = exp_en_q.pop_front();
          check("entry_en", tx_shfu[63:0], e_en);
          check("entry_nb", tx_shfu[319:64], e_nb);
        end
      end
    end
  end

  initial begin
    int cyc;
    rst_n      = 1'b0;
    meta_valid = 1'b0;
    meta       = '0;
    tx_ready   = 1'b0;
    txn_ctrl   = '0;
    clear_beat();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_axi_ready", axi_r_ready, 1'b0);
    check("rst_ctrl_ready", txn_ctrl_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_meta_ready", meta_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned two-beat request
    add_beat(32'h0, 1'b1, 1, 32, 1'b1, 2'b00);
    add_beat(32'h10, 1'b0, 0, 32, 1'b1, 2'b00);
    model_req(0, 0);
    send_meta(0, 0);
    drive_beat(req_q[0], cyc);
    check("aligned_b0_cycles", cyc, 1);
    drive_beat(req_q[1], cyc);
    check("aligned_b1_cycles", cyc, 1);
    req_q.delete();

    // Head misalignment: 24 + 32 + 8 nibbles
    add_beat(32'h1000_0008, 1'b1, 2, 32, 1'b1, 2'b00);
    add_beat(32'h1000_0018, 1'b0, 1, 32, 1'b1, 2'b00);
    add_beat(32'h1000_0028, 1'b0, 0, 8, 1'b1, 2'b00);
    model_req(0, 0);
    send_req(0, 0, 1'b0);

    // Straddle: vstart=10, sew=1 puts the first nibble at entry offset 40
    add_beat(32'h0, 1'b1, 1, 32, 1'b1, 2'b00);
    add_beat(32'h10, 1'b0, 0, 32, 1'b1, 2'b00);
    model_req(1, 10);
    send_meta(1, 10);
    drive_beat(req_q[0], cyc);
    check("straddle_b0_cycles", cyc, 2);
    drive_beat(req_q[1], cyc);
    check("straddle_b1_cycles", cyc, 1);
    req_q.delete();

    // Backpressure: fill both buffer slots, then release one entry
    wait_drain();
    tx_mode  = 1;
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) add_beat(32'h0, k == 0, 5 - k, 32, 1'b1, 2'b00);
    model_req(0, 0);
    send_meta(0, 0);
    for (int k = 0; k < 4; k++) begin
      drive_beat(req_q[k], cyc);
      check("bp_fill_cycles", cyc, 1);
    end
    set_beat(req_q[4]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall", axi_r_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_full_same_cycle", axi_r_ready, 1'b0);
    check("bp_tx_valid", tx_valid, 1'b1);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("bp_resume", axi_r_ready, 1'b1);
    @(posedge clk);
    #1;
    clear_beat();
    drive_beat(req_q[5], cyc);
    check("bp_last_cycles", cyc, 1);
    req_q.delete();
    tx_mode = 0;

    // Randomised requests
    for (int r = 0; r < 40; r++) begin
      int unsigned sew, vstart;
      sew    = $urandom_range(0, 3);
      vstart = $urandom_range(0, 63);
      gen_random_req();
      model_req(sew, vstart);
      send_req(sew, vstart, 1'b1);
    end

    // Reset in the middle of a request
    wait_drain();
    add_beat(32'h0, 1'b1, 1, 32, 1'b1, 2'b00);
    add_beat(32'h10, 1'b0, 0, 32, 1'b1, 2'b00);
    send_meta(0, 0);
    drive_beat(req_q[0], cyc);
    set_beat(req_q[1]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_axi_ready", axi_r_ready, 1'b0);
    check("mid_rst_ctrl_ready", txn_ctrl_ready, 1'b0);
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_meta_ready", meta_ready, 1'b1);
    check("mid_rst_err", err, 1'b0);
    clear_beat();
    req_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_idle_tx", tx_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    add_beat(32'h0, 1'b1, 1, 32, 1'b1, 2'b00);
    add_beat(32'h10, 1'b0, 0, 32, 1'b1, 2'b00);
    model_req(0, 0);
    send_req(0, 0, 1'b0);

    // Error response on beat 1
    wait_drain();
    add_beat(32'h0, 1'b1, 1, 32, 1'b1, 2'b00);
    add_beat(32'h10, 1'b0, 0, 32, 1'b1, 2'b10);
    model_req(0, 0);
    send_meta(0, 0);
    drive_beat(req_q[0], cyc);
    check("err_before", err, 1'b0);
    drive_beat(req_q[1], cyc);
    check("err_set", err, ErrExp);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", err, ErrExp);
    req_q.delete();

    wait_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
